aes_key_sched_ctrl: RTL and testbench

Sequential controller that wraps the AES-128 key schedule. It expands one cipher key into 11 round keys, one round per clock. The keys are held in an on-chip round-key buffer and served to the round datapath through an indexed read port with a valid handshake. A flattened 1408-bit view is also exported, bit-identical to the output format of the combinational `key_expansion` block, so the two can be cross-checked directly.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_key_round.sv | 19 +
 rtl/aes_key_sched_ctrl.sv | 83 ++++++++
 tb/tb_aes_key_sched_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM state type and S-box lookup
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// aes_key_round: one combinational AES-128 key-schedule round
module aes_key_round
    import aes_pkg::*;
(
    input  logic [127:0] w,
    input  logic [7:0]   rcon,
    output logic [127:0] w_nxt
);

    logic [31:0] t, n0, n1, n2;

    // RotWord then SubWord on the last word, Rcon in the top byte, then the word XOR chain
    assign t     = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rcon, 24'h0};
    assign n0    = w[127:96] ^ t;
    assign n1    = w[95:64] ^ n0;
    assign n2    = w[63:32] ^ n1;
    assign w_nxt = {n0, n1, n2, w[31:0] ^ n2};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequential AES-128 key expansion with round-key buffer and indexed read port
module aes_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [127:0]            key_in,
    input  logic                    start,
    output logic                    busy,
    output logic                    key_valid,
    input  logic                    rk_rd_en,
    input  logic [3:0]              rk_idx,
    output logic [127:0]            rk_out,
    output logic                    rk_rvalid,
    output logic [128*(NR+1)-1:0]   rk_all
);
    import aes_pkg::*;

    state_t       state;
    logic [3:0]   rc;
    logic [127:0] w, w_nxt;
    logic [127:0] slots [0:NR];
    logic [7:0]   rcon;

    assign rcon = RCON[rc - 4'd1];

    aes_key_round u_round (
        .w     (w),
        .rcon  (rcon),
        .w_nxt (w_nxt)
    );

    for (genvar i = 0; i <= NR; i++) begin : g_all
        assign rk_all[128*(NR-i) +: 128] = slots[i];
    end

    // Expansion FSM: capture the key on start, then write one round per cycle into the buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rc        <= '0;
            w         <= '0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            for (int i = 0; i <= NR; i++) slots[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        slots[0]  <= key_in;
                        w         <= key_in;
                        rc        <= 4'd1;
                        busy      <= 1'b1;
                        key_valid <= 1'b0;
                        state     <= EXPAND;
                    end
                end
                default: begin
                    slots[rc] <= w_nxt;
                    w         <= w_nxt;
                    rc        <= rc + 4'd1;
                    if (rc == 4'(NR)) begin
                        busy      <= 1'b0;
                        key_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
            endcase
        end
    end

    // Registered read port: out-of-range indices return zero, reads before key_valid are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_out    <= '0;
            rk_rvalid <= 1'b0;
        end else begin
            rk_rvalid <= rk_rd_en && key_valid;
            if (rk_rd_en && key_valid) rk_out <= (rk_idx <= 4'(NR)) ? slots[rk_idx] : '0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: randomized self-checking bench against a FIPS-197 word-level key expansion model
module tb_aes_key_sched_ctrl;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [127:0]   key_in;
    logic           start;
    logic           busy;
    logic           key_valid;
    logic           rk_rd_en;
    logic [3:0]     rk_idx;
    logic [127:0]   rk_out;
    logic           rk_rvalid;
    logic [1407:0]  rk_all;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [11];

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h5468617473206D79204B756E67204675;

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .start     (start),
        .busy      (busy),
        .key_valid (key_valid),
        .rk_rd_en  (rk_rd_en),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out),
        .rk_rvalid (rk_rvalid),
        .rk_all    (rk_all)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xtime(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 KeyExpansion over 44 words
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] wd [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) wd[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wd[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            wd[i] = wd[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] idx);
        rk_rd_en = 1'b1;
        rk_idx   = idx;
        tick();
        rk_rd_en = 1'b0;
    endtask

    task automatic kick(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
        check("kick_busy", busy, 1);
        check("kick_kv", key_valid, 0);
    endtask

    // Waits for key_valid counting edges since the accepted start; optionally pulses start at edge T+poke
    task automatic wait_done(input int cyc0, input int poke, input logic [127:0] k2);
        int cyc = cyc0;
        while (!key_valid && cyc < 20) begin
            if (cyc + 1 == poke) begin
                start  = 1'b1;
                key_in = k2;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check("latency", 128'(cyc), 10);
        check("done_busy", busy, 0);
    endtask

    // Back-to-back reads over every index, then the flattened view slot by slot
    task automatic check_keys(input logic [127:0] k);
        model_expand(k);
        rk_rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            tick();
            check("rd_valid", rk_rvalid, 1);
            check($sformatf("rd_idx%0d", i), rk_out, i <= 10 ? exp_rk[i] : 128'h0);
        end
        rk_rd_en = 1'b0;
        for (int i = 0; i < 11; i++)
            check($sformatf("rk_all%0d", i), rk_all[128*(10-i) +: 128], exp_rk[i]);
    endtask

    initial begin
        logic [127:0] old3, knew;
        logic         seen;
        build_sbox();
        rst_n = 1'b0; start = 1'b0; key_in = '0; rk_rd_en = 1'b0; rk_idx = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_kv", key_valid, 0);
        check("rst_rvalid", rk_rvalid, 0);
        check("rst_rkout", rk_out, 0);
        check("rst_all", |rk_all, 0);
        rst_n = 1'b1;
        rd(4'd0);
        check("idle_rvalid", rk_rvalid, 0);
        check("idle_rkout", rk_out, 0);
        check("idle_busy", busy, 0);

        kick(K1);
        wait_done(0, 0, '0);
        check_keys(K1);
        rd(4'd1);
        check("fips_rk1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(4'd10);
        check("fips_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        kick(K2);
        wait_done(0, 0, '0);
        check_keys(K2);
        rd(4'd1);
        check("k2_rk1", rk_out, 128'hE232FCF191129188B159E4E6D679A293);
        rd(4'd10);
        check("k2_rk10", rk_out, 128'h28FDDEF86DA4244ACCC0A4FE3B316F26);

        kick(K1);
        wait_done(0, 4, K2);
        check_keys(K1);
        rd(4'd12);
        check("oor_rvalid", rk_rvalid, 1);
        check("oor_rkout", rk_out, 0);

        kick(K2);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_kv", key_valid, 0);
        check("abort_all", |rk_all, 0);
        check("abort_rkout", rk_out, 0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen |= key_valid;
        end
        check("abort_never_valid", seen, 0);

        kick(K1);
        wait_done(0, 0, '0);
        check_keys(K1);
        old3 = exp_rk[3];
        knew = {$urandom, $urandom, $urandom, $urandom};
        rk_rd_en = 1'b1;
        rk_idx   = 4'd3;
        kick(knew);
        check("b2b_rvalid", rk_rvalid, 1);
        check("b2b_old", rk_out, old3);
        rk_idx = 4'd5;
        tick();
        rk_rd_en = 1'b0;
        check("b2b_exp_rvalid", rk_rvalid, 0);
        check("b2b_hold", rk_out, old3);
        wait_done(1, 0, '0);
        check_keys(knew);

        repeat (6) begin
            knew = {$urandom, $urandom, $urandom, $urandom};
            kick(knew);
            wait_done(0, 0, '0);
            check_keys(knew);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
